// File: rtl/oam_dma_bus.sv
// oam_dma_bus: memory-port front end for the sm83 core.
// Contains the OAM DMA engine (triggered by a write to 0xFF46), the HRAM
// (0xFF80-0xFFFE) and the arbiter for the single system memory port.
// Optional macro OAM_DMA_BLOCK_EN: when defined, the DMA owns the port for
// the whole transfer and the CPU is locked out of everything except HRAM
// and 0xFF46. When it is undefined, CPU accesses steal the port and stall
// the DMA for that cycle.
module oam_dma_bus #(
  parameter int DMA_LEN     = 160,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_write,
  output logic [7:0]  cpu_d_in,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_write,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_RD    = 2'd2;
  localparam logic [1:0] S_WR    = 2'd3;

  localparam logic [7:0] LAST_IDX  = 8'(DMA_LEN - 1);
  localparam logic [7:0] DELAY_INI = 8'(START_DELAY);

  logic [1:0] state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] index_q, index_d;
  logic [7:0] dly_q, dly_d;
  logic [7:0] buf_q, buf_d;
  logic       buf_vld_q, buf_vld_d;
  logic       rsel_mem_q, rsel_mem_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] hram_q [0:127];

  logic       is_hram, is_dma_reg, is_int;
  logic       dma_busy, xfer, cpu_steal, cpu_blocked, dma_port, trigger;
  logic [7:0] src_page, dma_wdata;

  // Address decode, arbitration and effective source page.
  always_comb begin
    is_hram    = (cpu_addr >= 16'hFF80) && (cpu_addr != 16'hFFFF);
    is_dma_reg = (cpu_addr == 16'hFF46);
    is_int     = is_hram | is_dma_reg;
    dma_busy   = (state_q != S_IDLE);
    xfer       = (state_q == S_RD) || (state_q == S_WR);
`ifdef OAM_DMA_BLOCK_EN
    cpu_steal   = 1'b0;
    cpu_blocked = dma_busy & ~is_int;
`else
    cpu_steal   = xfer & ~is_int;
    cpu_blocked = 1'b0;
`endif
    dma_port  = xfer & ~cpu_steal;
    trigger   = cpu_write & is_dma_reg;
    src_page  = (page_q >= 8'hE0) ? (page_q - 8'h20) : page_q;
    dma_wdata = buf_vld_q ? buf_q : mem_rdata;
  end

  // Memory port mux: CPU pass-through unless the DMA owns this cycle.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_d_out;
    mem_write = cpu_write & ~is_int & ~cpu_blocked;
    if (dma_port) begin
      if (state_q == S_RD) begin
        mem_addr  = {src_page, index_q};
        mem_write = 1'b0;
      end else begin
        mem_addr  = 16'hFE00 + {8'h00, index_q};
        mem_wdata = dma_wdata;
        mem_write = 1'b1;
      end
    end
  end

  // DMA sequencing; a stalled WR keeps the byte fetched by its RD in a buffer
  // because the following cycle's read data belongs to the CPU access.
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    index_d   = index_q;
    dly_d     = dly_q;
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    case (state_q)
      S_DELAY: begin
        if (dly_q <= 8'd1) state_d = S_RD;
        else               dly_d   = dly_q - 8'd1;
      end
      S_RD: begin
        buf_vld_d = 1'b0;
        if (dma_port) state_d = S_WR;
      end
      S_WR: begin
        if (dma_port) begin
          buf_vld_d = 1'b0;
          if (index_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            index_d = index_q + 8'd1;
            state_d = S_RD;
          end
        end else if (!buf_vld_q) begin
          buf_d     = mem_rdata;
          buf_vld_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (trigger) begin
      page_d    = cpu_d_out;
      index_d   = 8'h00;
      buf_vld_d = 1'b0;
      dly_d     = DELAY_INI;
      state_d   = (START_DELAY == 0) ? S_RD : S_DELAY;
    end
  end

  // CPU read path: internal regions are captured here, memory data is
  // taken straight from the synchronous memory output the next cycle.
  always_comb begin
    rsel_mem_d = ~is_int & ~cpu_blocked;
    rdata_d    = 8'hFF;
    if (is_hram)         rdata_d = hram_q[cpu_addr[6:0]];
    else if (is_dma_reg) rdata_d = page_q;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      page_q     <= 8'h00;
      index_q    <= 8'h00;
      dly_q      <= 8'h00;
      buf_q      <= 8'h00;
      buf_vld_q  <= 1'b0;
      rsel_mem_q <= 1'b0;
      rdata_q    <= 8'hFF;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      index_q    <= index_d;
      dly_q      <= dly_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
      rsel_mem_q <= rsel_mem_d;
      rdata_q    <= rdata_d;
    end
  end

  // HRAM storage, writable by the CPU at any time and never reset.
  always_ff @(posedge clk) begin
    if (cpu_write && is_hram) hram_q[cpu_addr[6:0]] <= cpu_d_out;
  end

  assign cpu_d_in   = rsel_mem_q ? mem_rdata : rdata_q;
  assign dma_active = dma_busy;

endmodule

// File: tb/tb_oam_dma_bus.sv
// Testbench for oam_dma_bus: random source pages/data, HRAM traffic,
// re-trigger, mid-transfer reset and (default build) cycle stealing.
module tb_oam_dma_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_write;
  logic [7:0]  cpu_d_in;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic [7:0]  mem_rdata;
  logic        dma_active;

  localparam logic [15:0] PARK = 16'hFF80;

  int n_vec = 0;
  int n_err = 0;
  int wr_count = 0;
  int act_cycles = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] exp_oam [0:159];

  oam_dma_bus dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out), .cpu_write(cpu_write),
    .cpu_d_in(cpu_d_in),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  // Synchronous system memory plus write/active-cycle monitors.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_write) begin
      mem[mem_addr] = mem_wdata;
      wr_count++;
    end
    if (dma_active) act_cycles++;
  end

  // Global watchdog so the run always ends.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic w);
    cpu_addr  = a;
    cpu_d_out = d;
    cpu_write = w;
    tick();
    cpu_addr  = PARK;
    cpu_write = 1'b0;
  endtask

  task automatic start_dma(input logic [7:0] page);
    logic [7:0] src;
    src = (page >= 8'hE0) ? page - 8'h20 : page;
    for (int i = 0; i < 160; i++) exp_oam[i] = mem[{src, 8'(i)}];
    applyStimulus(16'hFF46, page, 1'b1);
    wr_count   = 0;
    act_cycles = 0;
    checkOutput("active_after_trigger", {15'd0, dma_active}, 16'd1);
    tick();
    checkOutput("active_in_delay_next", {15'd0, dma_active}, 16'd1);
    checkOutput("first_rd_addr", mem_addr, {src, 8'h00});
    checkOutput("first_rd_nowrite", {15'd0, mem_write}, 16'd0);
  endtask

  task automatic wait_done(input string tag, input int exp_cycles);
    int n = 0;
    while (dma_active && n < 2000) begin
      tick();
      n++;
    end
    checkOutput({tag, "_finished"}, {15'd0, dma_active}, 16'd0);
    checkOutput({tag, "_active_cycles"}, 16'(act_cycles), 16'(exp_cycles));
    checkOutput({tag, "_write_pulses"}, 16'(wr_count), 16'd160);
  endtask

  task automatic check_oam(input string tag);
    for (int i = 0; i < 160; i++)
      checkOutput({tag, "_oam"}, {8'h00, mem[16'hFE00 + 16'(i)]}, {8'h00, exp_oam[i]});
  endtask

  task automatic wait_writes(input string tag, input int target);
    int n = 0;
    while (wr_count < target && n < 1000) begin
      tick();
      n++;
    end
    checkOutput({tag, "_reached"}, 16'(wr_count), 16'(target));
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d, p;
    rst       = 1'b1;
    cpu_addr  = 16'h1234;
    cpu_d_out = 8'h5A;
    cpu_write = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'hFEA0] = 8'h77;
    tick();
    tick();

    // Reset values and pass-through.
    checkOutput("rst_active", {15'd0, dma_active}, 16'd0);
    checkOutput("rst_mem_write", {15'd0, mem_write}, 16'd0);
    checkOutput("rst_cpu_d_in", {8'h00, cpu_d_in}, 16'h00FF);
    checkOutput("rst_mem_addr", mem_addr, 16'h1234);
    checkOutput("rst_mem_wdata", {8'h00, mem_wdata}, 16'h005A);
    rst = 1'b0;
    cpu_addr = PARK;
    tick();
    applyStimulus(16'hFF46, 8'h00, 1'b0);
    checkOutput("page_after_rst", {8'h00, cpu_d_in}, 16'h0000);

    // Idle memory read / write and internal write suppression.
    a = 16'h8000 + 16'($urandom_range(0, 16'h0FFF));
    applyStimulus(a, 8'h00, 1'b0);
    checkOutput("idle_mem_read", {8'h00, cpu_d_in}, {8'h00, mem[a]});
    d = 8'($urandom);
    cpu_addr = 16'hC800; cpu_d_out = d; cpu_write = 1'b1;
    #1;
    checkOutput("idle_pass_write", {15'd0, mem_write}, 16'd1);
    tick();
    checkOutput("idle_written", {8'h00, mem[16'hC800]}, {8'h00, d});
    cpu_addr = 16'hFF85;
    #1;
    checkOutput("hram_no_port_write", {15'd0, mem_write}, 16'd0);
    cpu_write = 1'b0; cpu_addr = PARK;

    // Reference transfer from page 0xC1 with i^0x5A pattern.
    for (int i = 0; i < 160; i++) mem[{8'hC1, 8'(i)}] = 8'(i) ^ 8'h5A;
    start_dma(8'hC1);
    wait_done("c1", 321);
    check_oam("c1");
    checkOutput("no_write_past_oam", {8'h00, mem[16'hFEA0]}, 16'h0077);

    // Echo-region page clamp.
    p = 8'hE0 + 8'($urandom_range(0, 31));
    start_dma(p);
    wait_done("echo", 321);
    check_oam("echo");

    // Random pages with HRAM traffic in the middle of the transfer.
    for (int t = 0; t < 2; t++) begin
      p = 8'($urandom);
      start_dma(p);
      applyStimulus(16'hFF90, 8'h3C, 1'b1);
      applyStimulus(16'hFF90, 8'h00, 1'b0);
      checkOutput("hram_ff90", {8'h00, cpu_d_in}, 16'h003C);
      for (int k = 0; k < 3; k++) begin
        a = 16'hFF80 + 16'($urandom_range(0, 126));
        d = 8'($urandom);
        applyStimulus(a, d, 1'b1);
        applyStimulus(a, 8'h00, 1'b0);
        checkOutput("hram_rand", {8'h00, cpu_d_in}, {8'h00, d});
      end
      applyStimulus(16'hFF46, 8'h00, 1'b0);
      checkOutput("page_read", {8'h00, cpu_d_in}, {8'h00, p});
`ifdef OAM_DMA_BLOCK_EN
      applyStimulus(16'hC000, 8'h00, 1'b0);
      checkOutput("blocked_read", {8'h00, cpu_d_in}, 16'h00FF);
      d = mem[16'hC000];
      applyStimulus(16'hC000, ~d, 1'b1);
      checkOutput("blocked_write", {8'h00, mem[16'hC000]}, {8'h00, d});
`endif
      wait_done("rand", 321);
      check_oam("rand");
    end

    // Re-trigger with page 0xD0 at byte 50.
    start_dma(8'hC3);
    wait_writes("retrig50", 50);
    start_dma(8'hD0);
    wait_done("retrig", 321);
    check_oam("retrig");

    // Reset in the middle of a transfer at byte 80.
    for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = 8'hAA;
    start_dma(8'hC5);
    wait_writes("rst80", 80);
    rst = 1'b1;
    #1;
    checkOutput("midrst_active", {15'd0, dma_active}, 16'd0);
    checkOutput("midrst_mem_write", {15'd0, mem_write}, 16'd0);
    checkOutput("midrst_cpu_d_in", {8'h00, cpu_d_in}, 16'h00FF);
    tick();
    tick();
    rst = 1'b0;
    wr_count = 0;
    repeat (400) tick();
    checkOutput("midrst_no_writes", 16'(wr_count), 16'd0);
    checkOutput("midrst_byte79", {8'h00, mem[16'hFE4F]}, {8'h00, exp_oam[79]});
    checkOutput("midrst_byte80", {8'h00, mem[16'hFE50]}, 16'h00AA);
    applyStimulus(16'hFF46, 8'h00, 1'b0);
    checkOutput("midrst_page", {8'h00, cpu_d_in}, 16'h0000);

`ifndef OAM_DMA_BLOCK_EN
    // Cycle stealing: 10 CPU memory reads stretch the transfer by 10 cycles.
    p = 8'($urandom_range(0, 8'hDF));
    start_dma(p);
    repeat (20) tick();
    for (int k = 0; k < 10; k++) begin
      a = 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
      applyStimulus(a, 8'h00, 1'b0);
      checkOutput("steal_read", {8'h00, cpu_d_in}, {8'h00, mem[a]});
      tick();
    end
    wait_done("steal", 331);
    check_oam("steal");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
